// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Stalls EX while iterating; result = {hi = remainder, lo = quotient}.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_div,
  input  logic               start,
  input  logic               annul,
  output logic               div_stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, DIV_ZERO, ON, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_lat, dsr, dvd, rem, rem_n, dvd_n, a_abs, b_abs;
  logic [WIDTH:0] part, diff;
  logic q_neg, r_neg, go, last;
  assign go = state == IDLE && start && !annul;
  // |0x80..0| wraps back to 0x80..0, which is the correct unsigned magnitude
  assign a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_abs = (signed_div && b[WIDTH-1]) ? -b : b;
  assign part = {rem, dvd[WIDTH-1]};
  assign diff = part - {1'b0, dsr};
  assign rem_n = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dvd_n = {dvd[WIDTH-2:0], ~diff[WIDTH]};
  assign last = cnt == CW'(WIDTH - 1);
  assign div_stall = go || state == ON || state == DIV_ZERO;
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = go ? (b == '0 ? DIV_ZERO : ON) : IDLE;
      DIV_ZERO: next = annul ? IDLE : DONE;
      ON:       next = annul ? IDLE : (last ? DONE : ON);
      default:  next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      ready  <= 1'b0;
      result <= '0;
      a_lat  <= '0;
      dsr    <= '0;
      dvd    <= '0;
      rem    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      state <= next;
      ready <= next == DONE;
      if (go) begin
        a_lat <= a;
        dsr   <= b_abs;
        dvd   <= a_abs;
        rem   <= '0;
        cnt   <= '0;
        q_neg <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg <= signed_div & a[WIDTH-1];
      end else if (state == ON) begin
        rem <= rem_n;
        dvd <= dvd_n;
        cnt <= cnt + 1'b1;
      end
      if (state == ON && next == DONE)
        result <= {r_neg ? -rem_n : rem_n, q_neg ? -dvd_n : dvd_n};
      else if (state == DIV_ZERO && next == DONE)
        result <= {a_lat, {WIDTH{1'b1}}};
    end
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, sitting beside the EX-stage ALU.
- Drives the same hi/lo write path as MULT/MULTU: hi = remainder, lo = quotient.
- Stalls the pipeline while iterating; supports cancellation when EX is flushed by an exception or branch.

Parameters:
- WIDTH, 32, operand width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- resetn  input  1  asynchronous active-low reset
- a  input  WIDTH  dividend (rs)
- b  input  WIDTH  divisor (rt)
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- start  input  1  request a division; sampled only in IDLE
- annul  input  1  abort the current operation (flush)
- div_stall  output  1  combinational; holds the pipeline while the divide is in progress
- ready  output  1  registered; result valid this cycle (one-cycle pulse)
- result  output  2*WIDTH  registered; {hi = remainder, lo = quotient}

Behaviour:
- Reset (resetn low, asynchronous, any state): state to IDLE, cnt to 0, ready to 0, result to 0. All internal operand and remainder registers clear. An in-flight divide is lost silently.
- States: IDLE, DIV_ZERO, ON, END. Encoding is free.
- IDLE:
  - On an edge with start=1 and annul=0, latch a, b and signed_div.
  - Next state is DIV_ZERO if b==0, else ON with cnt=0.
  - start=1 with annul=1 is ignored.
  - Operand changes after the start edge have no effect.
- Signed operands: operate on |a| and |b| as unsigned. Record quotient sign = a[31]^b[31] and remainder sign = a[31].
  - |0x80000000| = 0x80000000 as unsigned.
- ON: one restoring iteration per clock.
  - Shift {rem, dvd} left 1 and trial-subtract |b| from the (WIDTH+1)-bit partial remainder.
  - If the subtraction is non-negative, keep the difference and set quotient bit to 1; otherwise restore and set 0.
  - cnt increments each iteration. The edge that performs iteration WIDTH (cnt reaches WIDTH) moves to END.
  - On that same edge: result = fixed-up values (quotient negated if its sign is set, remainder negated if its sign is set), and ready = 1.
- DIV_ZERO: the next edge moves to END with result = {a_latched, all-ones} and ready = 1. Deterministic; no exception is raised.
- END: ready = 1 for exactly one cycle. The next edge returns to IDLE with ready = 0. A start seen in END is ignored.
- Latency: start sampled at edge E0; ready high in the cycle after edge E32 (E1 for divide-by-zero); back in IDLE after E33.
- result is held unchanged from when it loads until the next completed divide or reset.
- div_stall = (state==IDLE & start & ~annul) | state==ON | state==DIV_ZERO.
  - Low in END, so the pipeline advances and captures result while ready=1.
- annul=1 in ON or DIV_ZERO: next edge goes to IDLE, ready stays 0, and result keeps its previous value. annul in END has no effect; ready still pulses. annul has priority over iteration on the same edge.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no trap.
- Back-to-back divides: a new start is accepted on the IDLE cycle immediately after END.

Test Plan:
- DIVU: a=100, b=7, start for 1 cycle at E0. Required: div_stall high E0..E32; ready high only after E32; result = {0x00000002, 0x0000000E}; IDLE after E33.
- DIV: a=0xFFFFFFF9 (-7), b=2. Required: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with a=7, b=0xFFFFFFFE: lo=0xFFFFFFFD, hi=0x00000001.
- Divide by zero: a=0x12345678, b=0. Required: ready after E1; result = {0x12345678, 0xFFFFFFFF}; div_stall low from E1.
- Extremes: signed 0x80000000/0xFFFFFFFF gives {0, 0x80000000}. Unsigned with the same operands gives {0x80000000, 0}. Unsigned 0xFFFFFFFF/1 gives {0, 0xFFFFFFFF}.
- annul at cnt=10: required ready never asserts, result keeps its prior value, state is IDLE next cycle, and a new start the following cycle completes correctly. A start held high during ON (operands changed) is ignored; the first result is unaffected.
- resetn pulled low asynchronously mid-ON (between edges): required ready=0 and result=0 immediately. After release, a fresh 100/7 yields {2, 14} with full latency.
